exec_unit: RTL
==============

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have port START  input  1  operation valid this cycle; sampled on CLK rising edge.
REQ-004 SHALL have port OPCODE  input  3  000 MOV, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRL, 111 ROR.
REQ-005 SHALL have port DATA1  input  8  operand A; register-file read port 1 data.
REQ-006 SHALL have port DATA2  input  8  operand B; register-file read port 2 data; bits [2:0] give the shift amount.
REQ-007 SHALL have port DESTADDR  input  3  destination register index for the result.
REQ-008 SHALL have port RESULT  output  8  registered result; drives register-file write data.
REQ-009 SHALL have port WRADDR  output  3  registered destination index; drives register-file write address.
REQ-010 SHALL have port WRITE  output  1  one-cycle result-valid pulse; drives register-file write enable.
REQ-011 SHALL have port BUSY  output  1  registered; high while a MUL is in progress; upstream holds START low.
REQ-012 SHALL have port ZERO  output  1  registered; RESULT==0, updated only with WRITE.

Function
REQ-013 SHALL sample DATA1, DATA2, OPCODE and DESTADDR only on an accepted START; later input changes SHALL NOT affect the result.
REQ-014 SHALL accept START only when the FSM is in IDLE; START while BUSY is high SHALL be ignored and SHALL produce no WRITE.
REQ-015 SHALL implement FSM states IDLE and MUL: IDLE->MUL on accepted MUL START; MUL->IDLE after the 8th iteration; all other opcodes remain in IDLE.
REQ-016 Single-cycle ops (MOV, ADD, AND, OR, SLL, SRL, ROR) SHALL load RESULT, WRADDR and ZERO and pulse WRITE on the same edge that accepts START (1-cycle latency).
REQ-017 MOV SHALL output DATA2; ADD SHALL output (DATA1+DATA2) mod 256 with the carry discarded; AND and OR SHALL be bitwise.
REQ-018 SLL and SRL SHALL shift DATA1 by DATA2[2:0] and zero-fill; ROR SHALL rotate DATA1 right by DATA2[2:0]; a shift amount of 0 SHALL pass DATA1 through unchanged.
REQ-019 MUL SHALL be shift-add with 1 multiplier bit per cycle: operands are captured and BUSY rises at edge 0; iterations run on edges 1..8; RESULT, WRADDR and ZERO load, WRITE pulses and BUSY falls at edge 8.
REQ-020 MUL SHALL output the low 8 bits of DATA1*DATA2; the upper bits are discarded.
REQ-021 Outside a WRITE pulse, WRITE SHALL be 0 and RESULT, WRADDR and ZERO SHALL hold their last values.
REQ-022 Back-to-back single-cycle STARTs SHALL each produce one WRITE, one per cycle.
REQ-023 A START presented on the MUL completion edge (edge 8) SHALL be ignored; the earliest next accept is edge 9.

Reset
REQ-024 While RESET is sampled high: RESULT=0, WRADDR=0, WRITE=0, BUSY=0, ZERO=0, FSM=IDLE, iteration count=0.
REQ-025 RESET SHALL take priority over START on the same edge.
REQ-026 RESET during MUL SHALL abort the operation with no WRITE, then or later.

Structure
REQ-027 Shared package exec_pkg SHALL hold the opcode constants, the FSM state encoding and MUL_CYCLES=8.
REQ-028 The sequential multiplier SHALL be sub-module mul8_seq (start, operands, done, 8-bit product); exec_unit SHALL hold the FSM, single-cycle ALU and output registers.

Verification
REQ-029 Reset: RESET high 2 cycles with START=1 -> RESULT=0, WRADDR=0, WRITE=0, BUSY=0, ZERO=0 throughout.
REQ-030 ADD: DATA1=200, DATA2=100, DESTADDR=3 -> next cycle RESULT=44, WRADDR=3, WRITE=1 for 1 cycle, ZERO=0.
REQ-031 MUL: 13*11, DESTADDR=5 -> BUSY high 8 cycles, a single WRITE with RESULT=143, WRADDR=5; then 16*16 -> RESULT=0, ZERO=1.
REQ-032 START during BUSY: ADD issued at edge 3 of a MUL 13*11 -> no extra WRITE; MUL result 143 unchanged.
REQ-033 RESET at edge 4 of a MUL -> no WRITE ever, BUSY=0 and RESULT=0 after that edge; a following ADD 1+1 -> RESULT=2.
REQ-034 Shifts: ROR 0x81 by 1 -> 0xC0; SRL 0x80 by 7 -> 0x01; SLL 0xFF by 0 -> 0xFF; SLL 0x01 by 7 -> 0x80.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg -- shared definitions for the execution unit.
//   opcode_e   : 3-bit operation encoding seen on OPCODE
//   state_e    : execution FSM state encoding (IDLE / MUL)
//   MUL_CYCLES : number of shift-add iterations of the multiplier
//   alu_calc   : combinational result of the single-cycle operations
package exec_pkg;

  localparam int MUL_CYCLES = 8;

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_ROR = 3'b111
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Single-cycle ALU. MUL is not computed here; it returns 0 for it.
  function automatic logic [7:0] alu_calc(input opcode_e op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [15:0] dbl;
    logic [2:0]  sh;
    logic [7:0]  res;
    sh  = b[2:0];
    // Rotating the doubled word right keeps the wrapped bits in the low byte.
    dbl = {a, a} >> sh;
    res = 8'd0;
    case (op)
      OP_MOV:  res = b;
      OP_ADD:  res = a + b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_ROR:  res = dbl[7:0];
      default: res = 8'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul8_seq.sv
// mul8_seq -- 8x8 shift-add multiplier, one multiplier bit per cycle,
// keeping only the low 8 bits of the product.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (aborts a running multiply)
//   start_i   : capture a_i/b_i and begin; ignored while running
//   a_i, b_i  : operands
//   done_o    : high during the cycle whose rising edge performs the last iteration
//   product_o : product valid while done_o is high
module mul8_seq
  import exec_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       done_o,
  output logic [7:0] product_o
);

  logic       running_q;
  logic [2:0] cnt_q;
  logic [7:0] acc_q, mcand_q, mplier_q;
  logic [7:0] acc_d;

  // Accumulator value after the iteration performed at the next edge.
  // done_o/product_o are combinational so the parent can register the
  // final product on the same edge as the last iteration.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : 8'd0);
  end

  assign done_o    = running_q && (cnt_q == 3'(MUL_CYCLES - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      running_q <= 1'b0;
      cnt_q     <= 3'd0;
      acc_q     <= 8'd0;
      mcand_q   <= 8'd0;
      mplier_q  <= 8'd0;
    end else if (running_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 3'd1;
      if (done_o) running_q <= 1'b0;
    end else if (start_i) begin
      running_q <= 1'b1;
      cnt_q     <= 3'd0;
      acc_q     <= 8'd0;
      mcand_q   <= a_i;
      mplier_q  <= b_i;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit -- execution stage: single-cycle ALU ops plus a sequential MUL,
// writing results to a register file.
//   CLK, RESET  : clock, synchronous active-high reset
//   START       : operation valid; accepted only in IDLE (ready = !BUSY).
//                 A START while not ready is dropped, not stalled.
//   OPCODE      : operation select
//   DATA1/DATA2 : operands, captured only on an accepted START
//   DESTADDR    : destination register index
//   RESULT      : registered result (register-file write data)
//   WRADDR      : registered destination (register-file write address)
//   WRITE       : one-cycle write enable pulse
//   BUSY        : high while a MUL is in progress
//   ZERO        : RESULT==0, updated only together with WRITE
module exec_unit
  import exec_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] OPCODE,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [2:0] DESTADDR,
  output logic [7:0] RESULT,
  output logic [2:0] WRADDR,
  output logic       WRITE,
  output logic       BUSY,
  output logic       ZERO
);

  state_e     state_q;
  logic [7:0] result_q;
  logic [2:0] wraddr_q;
  logic [2:0] dest_q;      // destination of the MUL in flight
  logic       write_q, busy_q, zero_q;

  opcode_e    op;
  logic [7:0] alu_res;
  logic       accept, mul_start, mul_done;
  logic [7:0] mul_prod;

  always_comb begin
    op        = opcode_e'(OPCODE);
    alu_res   = alu_calc(op, DATA1, DATA2);
    accept    = START && (state_q == ST_IDLE);
    // Reset wins over START, so a MUL is never launched on a reset edge.
    mul_start = accept && (op == OP_MUL) && !RESET;
  end

  mul8_seq u_mul (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .start_i   (mul_start),
    .a_i       (DATA1),
    .b_i       (DATA2),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      result_q <= 8'd0;
      wraddr_q <= 3'd0;
      dest_q   <= 3'd0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
              dest_q  <= DESTADDR;
            end else begin
              result_q <= alu_res;
              wraddr_q <= DESTADDR;
              zero_q   <= (alu_res == 8'd0);
              write_q  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            result_q <= mul_prod;
            wraddr_q <= dest_q;
            zero_q   <= (mul_prod == 8'd0);
            write_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RESULT = result_q;
  assign WRADDR = wraddr_q;
  assign WRITE  = write_q;
  assign BUSY   = busy_q;
  assign ZERO   = zero_q;

endmodule
